// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding select, load-use / full interlock,
// multiply/divide occupancy tracking, branch flush and a saturating stall counter.
module pipe_hazard_ctrl #(
   parameter int RW         = 5,
   parameter int FWD_EN     = 1,
   parameter int MD_LAT     = 4,
   parameter int DELAY_SLOT = 1,
   parameter int SCW        = 16
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [RW-1:0] rs,
   input  logic [RW-1:0] rt,
   input  logic          use_rs,
   input  logic          use_rt,
   input  logic [RW-1:0] ern,
   input  logic [RW-1:0] mrn,
   input  logic          ewreg,
   input  logic          em2reg,
   input  logic          mwreg,
   input  logic          mm2reg,
   input  logic          md_start,
   input  logic          md_read,
   input  logic          br_taken,
   output logic          wpcir,
   output logic          bubble,
   output logic          flush_d,
   output logic [1:0]    fwda,
   output logic [1:0]    fwdb,
   output logic          md_busy,
   output logic          md_done,
   output logic [SCW-1:0] stall_cnt
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

   localparam logic [3:0] LAT_M1 = 4'(MD_LAT - 1);

   md_state_t  state;
   logic [3:0] cnt;

   logic ex_rs, ex_rt, mem_rs, mem_rt;
   logic data_hazard, md_hazard, stall, accept;

   // A zero destination is never a real producer, so it can never match.
   assign ex_rs  = use_rs & ewreg & (ern != '0) & (ern == rs);
   assign ex_rt  = use_rt & ewreg & (ern != '0) & (ern == rt);
   assign mem_rs = use_rs & mwreg & (mrn != '0) & (mrn == rs);
   assign mem_rt = use_rt & mwreg & (mrn != '0) & (mrn == rt);

   always_comb begin
      fwda = 2'b00;
      fwdb = 2'b00;
      if (FWD_EN != 0) begin
         if (ex_rs && !em2reg)       fwda = 2'b01;
         else if (mem_rs && !mm2reg) fwda = 2'b10;
         else if (mem_rs && mm2reg)  fwda = 2'b11;
         if (ex_rt && !em2reg)       fwdb = 2'b01;
         else if (mem_rt && !mm2reg) fwdb = 2'b10;
         else if (mem_rt && mm2reg)  fwdb = 2'b11;
      end
   end

   always_comb begin
      if (FWD_EN != 0) data_hazard = (ex_rs | ex_rt) & em2reg;
      else             data_hazard = ex_rs | ex_rt | mem_rs | mem_rt;
   end

   // md_busy is low in DONE, so a result that is ready this cycle never stalls.
   assign md_hazard = md_busy & (md_start | md_read);
   assign stall     = data_hazard | md_hazard;
   assign wpcir     = ~stall;
   assign bubble    = stall;
   assign flush_d   = (DELAY_SLOT == 0) & br_taken & ~stall;
   assign accept    = md_start & ~stall & (state != BUSY);

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         md_busy   <= 1'b0;
         md_done   <= 1'b0;
         stall_cnt <= '0;
      end else begin
         md_busy <= 1'b0;
         md_done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state   <= BUSY;
                  cnt     <= LAT_M1;
                  md_busy <= 1'b1;
               end
            end
            BUSY: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state   <= DONE;
                  md_done <= 1'b1;
               end else begin
                  md_busy <= 1'b1;
               end
            end
            DONE: begin
               if (accept) begin
                  state   <= BUSY;
                  cnt     <= LAT_M1;
                  md_busy <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: a forwarding/no-delay-slot instance and an interlock/delay-slot
// instance share directed stimulus; a negedge monitor pops expected records.
module tb_pipe_hazard_ctrl;

   logic       clock;
   logic       reset;
   logic [4:0] rs, rt, ern, mrn;
   logic       use_rs, use_rt, ewreg, em2reg, mwreg, mm2reg;
   logic       md_start, md_read, br_taken;

   logic       a_wpcir, a_bubble, a_flush, a_busy, a_done;
   logic [1:0] a_fwda, a_fwdb;
   logic [3:0] a_scnt;
   logic       b_wpcir, b_bubble, b_flush, b_busy, b_done;
   logic [1:0] b_fwda, b_fwdb;
   logic [15:0] b_scnt;

   pipe_hazard_ctrl #(.RW(5), .FWD_EN(1), .MD_LAT(4), .DELAY_SLOT(0), .SCW(4)) u_fwd (
      .clock(clock), .reset(reset), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
      .ern(ern), .mrn(mrn), .ewreg(ewreg), .em2reg(em2reg), .mwreg(mwreg), .mm2reg(mm2reg),
      .md_start(md_start), .md_read(md_read), .br_taken(br_taken),
      .wpcir(a_wpcir), .bubble(a_bubble), .flush_d(a_flush), .fwda(a_fwda), .fwdb(a_fwdb),
      .md_busy(a_busy), .md_done(a_done), .stall_cnt(a_scnt));

   pipe_hazard_ctrl #(.RW(5), .FWD_EN(0), .MD_LAT(4), .DELAY_SLOT(1), .SCW(16)) u_ilk (
      .clock(clock), .reset(reset), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
      .ern(ern), .mrn(mrn), .ewreg(ewreg), .em2reg(em2reg), .mwreg(mwreg), .mm2reg(mm2reg),
      .md_start(md_start), .md_read(md_read), .br_taken(br_taken),
      .wpcir(b_wpcir), .bubble(b_bubble), .flush_d(b_flush), .fwda(b_fwda), .fwdb(b_fwdb),
      .md_busy(b_busy), .md_done(b_done), .stall_cnt(b_scnt));

   // -1 in any field means "not checked in this cycle".
   typedef struct {
      string tag;
      int a_wpcir, a_bubble, a_flush, a_fwda, a_fwdb, a_busy, a_done, a_scnt;
      int b_wpcir, b_bubble, b_flush, b_fwda, b_fwdb, b_busy, b_done, b_scnt;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   initial begin
      clock = 1'b1;
      forever #5 clock = ~clock;
   end

   function automatic exp_t dc(string t);
      exp_t e;
      e.tag = t;
      e.a_wpcir = -1; e.a_bubble = -1; e.a_flush = -1; e.a_fwda = -1;
      e.a_fwdb  = -1; e.a_busy   = -1; e.a_done  = -1; e.a_scnt = -1;
      e.b_wpcir = -1; e.b_bubble = -1; e.b_flush = -1; e.b_fwda = -1;
      e.b_fwdb  = -1; e.b_busy   = -1; e.b_done  = -1; e.b_scnt = -1;
      return e;
   endfunction

   function automatic int chk(string tag, string f, int act, int req);
      if (req < 0) return 0;
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s.%s actual=%0d required=%0d", tag, f, act, req);
         return 1;
      end
      return 0;
   endfunction

   // Monitor: one expected record per cycle, compared mid-cycle.
   initial begin
      exp_t e;
      int   n;
      forever begin
         @(negedge clock);
         if (q.size() > 0) begin
            e = q.pop_front();
            n = 0;
            n += chk(e.tag, "a_wpcir",  int'(a_wpcir),  e.a_wpcir);
            n += chk(e.tag, "a_bubble", int'(a_bubble), e.a_bubble);
            n += chk(e.tag, "a_flush",  int'(a_flush),  e.a_flush);
            n += chk(e.tag, "a_fwda",   int'(a_fwda),   e.a_fwda);
            n += chk(e.tag, "a_fwdb",   int'(a_fwdb),   e.a_fwdb);
            n += chk(e.tag, "a_busy",   int'(a_busy),   e.a_busy);
            n += chk(e.tag, "a_done",   int'(a_done),   e.a_done);
            n += chk(e.tag, "a_scnt",   int'(a_scnt),   e.a_scnt);
            n += chk(e.tag, "b_wpcir",  int'(b_wpcir),  e.b_wpcir);
            n += chk(e.tag, "b_bubble", int'(b_bubble), e.b_bubble);
            n += chk(e.tag, "b_flush",  int'(b_flush),  e.b_flush);
            n += chk(e.tag, "b_fwda",   int'(b_fwda),   e.b_fwda);
            n += chk(e.tag, "b_fwdb",   int'(b_fwdb),   e.b_fwdb);
            n += chk(e.tag, "b_busy",   int'(b_busy),   e.b_busy);
            n += chk(e.tag, "b_done",   int'(b_done),   e.b_done);
            n += chk(e.tag, "b_scnt",   int'(b_scnt),   e.b_scnt);
            $display("txn %-10s errors=%0d", e.tag, n);
         end
      end
   end

   task automatic clr();
      rs = '0; rt = '0; ern = '0; mrn = '0;
      use_rs = 0; use_rt = 0; ewreg = 0; em2reg = 0; mwreg = 0; mm2reg = 0;
      md_start = 0; md_read = 0; br_taken = 0;
   endtask

   task automatic apply(exp_t e);
      q.push_back(e);
      @(posedge clock);
      #1;
   endtask

   task automatic md_vec(string t, bit st, bit rd, int busy, int done, int wp);
      exp_t e;
      clr(); md_start = st; md_read = rd;
      e = dc(t); e.a_busy = busy; e.a_done = done; e.a_wpcir = wp; e.a_bubble = 1 - wp;
      apply(e);
   endtask

   initial begin
      exp_t e;
      clr();
      reset = 1;
      apply(dc("rst0"));
      e = dc("rst1"); e.a_busy = 0; e.a_done = 0; e.a_scnt = 0; e.a_wpcir = 1;
      e.b_busy = 0; e.b_done = 0; e.b_scnt = 0; e.b_wpcir = 1;
      apply(e);
      reset = 0;

      clr(); ern = 5; ewreg = 1; rs = 5; use_rs = 1;
      e = dc("exe_fwd"); e.a_fwda = 1; e.a_fwdb = 0; e.a_wpcir = 1; e.a_bubble = 0;
      e.b_wpcir = 0; e.b_bubble = 1; e.b_fwda = 0; e.b_scnt = 0;
      apply(e);

      mrn = 5; mwreg = 1;
      e = dc("exe_pri"); e.a_fwda = 1; e.a_wpcir = 1; e.b_wpcir = 0; e.b_scnt = 1;
      apply(e);

      clr(); mrn = 5; mwreg = 1; rs = 5; use_rs = 1;
      e = dc("mem_alu"); e.a_fwda = 2; e.a_wpcir = 1; e.b_wpcir = 0; e.b_fwda = 0; e.b_scnt = 2;
      apply(e);

      use_rs = 0;
      e = dc("use_off"); e.a_fwda = 0; e.b_wpcir = 1; e.b_scnt = 3;
      apply(e);

      clr(); ern = 7; ewreg = 1; em2reg = 1; rt = 7; use_rt = 1; br_taken = 1;
      e = dc("load_use"); e.a_wpcir = 0; e.a_bubble = 1; e.a_flush = 0; e.a_scnt = 0;
      e.b_wpcir = 0; e.b_flush = 0; e.b_scnt = 3;
      apply(e);

      clr(); mrn = 7; mwreg = 1; mm2reg = 1; rt = 7; use_rt = 1;
      e = dc("load_mem"); e.a_fwdb = 3; e.a_fwda = 0; e.a_wpcir = 1; e.a_scnt = 1;
      e.b_wpcir = 0; e.b_fwdb = 0; e.b_scnt = 4;
      apply(e);

      clr(); ern = 0; ewreg = 1; rs = 0; use_rs = 1;
      e = dc("zero_reg"); e.a_fwda = 0; e.a_wpcir = 1; e.a_scnt = 1; e.b_wpcir = 1; e.b_scnt = 5;
      apply(e);

      clr(); mrn = 3; mwreg = 1; rs = 3; use_rs = 1;
      e = dc("ilk_mem"); e.a_fwda = 2; e.a_wpcir = 1; e.b_wpcir = 0; e.b_bubble = 1;
      e.b_fwda = 0; e.b_scnt = 5;
      apply(e);

      clr(); br_taken = 1;
      e = dc("branch"); e.a_flush = 1; e.a_wpcir = 1; e.b_flush = 0; e.b_scnt = 6;
      apply(e);

      // Single multiply: accept, three busy cycles, done pulse; mfhi waits.
      md_vec("md_c0", 1, 0, 0, 0, 1);
      md_vec("md_c1", 0, 0, 1, 0, 1);
      md_vec("md_c2", 0, 1, 1, 0, 0);
      md_vec("md_c3", 0, 1, 1, 0, 0);
      md_vec("md_c4", 0, 1, 0, 1, 1);
      clr();
      e = dc("md_c5"); e.a_busy = 0; e.a_done = 0; e.a_scnt = 3;
      apply(e);

      // Back-to-back: a new start in DONE is accepted without a stall.
      md_vec("bb_c0", 1, 0, 0, 0, 1);
      md_vec("bb_c1", 0, 0, 1, 0, 1);
      md_vec("bb_c2", 0, 0, 1, 0, 1);
      md_vec("bb_c3", 0, 0, 1, 0, 1);
      md_vec("bb_done", 1, 0, 0, 1, 1);
      md_vec("bb_n1", 0, 0, 1, 0, 1);

      clr(); reset = 1;
      e = dc("rst_mid"); e.a_busy = 1; e.a_done = 0;
      apply(e);
      reset = 0;
      e = dc("rst_aft0"); e.a_busy = 0; e.a_done = 0; e.a_scnt = 0; e.b_scnt = 0;
      apply(e);
      for (int k = 1; k < 4; k++) begin
         e = dc($sformatf("rst_aft%0d", k)); e.a_busy = 0; e.a_done = 0;
         apply(e);
      end

      // Reset beats an accept; combinational outputs keep following inputs.
      clr(); reset = 1; md_start = 1; ern = 5; ewreg = 1; rs = 5; use_rs = 1;
      e = dc("rst_acc"); e.a_fwda = 1; e.a_wpcir = 1; e.b_wpcir = 0;
      apply(e);
      clr(); reset = 0;
      e = dc("rst_acc1"); e.a_busy = 0; e.a_scnt = 0; e.b_scnt = 0;
      apply(e);

      clr(); ern = 7; ewreg = 1; em2reg = 1; rs = 7; use_rs = 1;
      for (int k = 0; k < 18; k++) begin
         e = dc($sformatf("sat%0d", k));
         e.a_scnt = (k > 15) ? 15 : k;
         e.b_scnt = k;
         e.a_wpcir = 0;
         apply(e);
      end
      clr();

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
      if (q.size() > 0) begin
         failures++;
         $display("FAIL drain actual=%0d required=0", q.size());
      end
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL provide parameter RW, default 5: register-number width.
REQ-002 SHALL provide parameter FWD_EN, default 1: 1 = forwarding with load-use interlock; 0 = full interlock, no forwarding.
REQ-003 SHALL provide parameter MD_LAT, default 4, legal 2..15: multiply/divide unit latency in cycles.
REQ-004 SHALL provide parameter DELAY_SLOT, default 1: 1 = branch delay slot, no flush; 0 = flush the decode instruction on a taken branch.
REQ-005 SHALL provide parameter SCW, default 16: stall-counter width.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 clock  in  1  rising-edge clock.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 rs, rt  in  RW  decode-stage source registers; use_rs, use_rt  in  1  source actually read.
REQ-010 ern, mrn  in  RW  EXE / MEM destination registers; ewreg, em2reg, mwreg, mm2reg  in  1  write-enable and load flags.
REQ-011 md_start  in  1  decode holds a mul/div; md_read  in  1  decode holds mfhi/mflo.
REQ-012 br_taken  in  1  decode-stage branch/jump resolved taken.
REQ-013 wpcir  out  1  1 = PC and IF/ID advance; 0 = hold.
REQ-014 bubble  out  1  ID/EX control signals forced to 0.
REQ-015 flush_d  out  1  IF/ID instruction replaced with nop.
REQ-016 fwda, fwdb  out  2  00 regfile, 01 EXE ALU, 10 MEM ALU, 11 MEM load data.
REQ-017 md_busy  out  1  mul/div in progress; md_done  out  1  one-cycle result-ready pulse.
REQ-018 stall_cnt  out  SCW  saturating count of stall cycles.

Function
REQ-019 Match on a source SHALL require: corresponding use_* = 1, write-enable = 1, dest != 0, dest == source.
REQ-020 With FWD_EN=1, fwda SHALL be 01 on EXE match with em2reg=0; otherwise 10 on MEM match with mm2reg=0; otherwise 11 on MEM match with mm2reg=1; otherwise 00. fwdb SHALL follow the same rules using rt. EXE SHALL have priority over MEM.
REQ-021 With FWD_EN=0, fwda and fwdb SHALL be 00 at all times.
REQ-022 Load-use hazard, FWD_EN=1: an EXE match with em2reg=1 on either source.
REQ-023 Data hazard, FWD_EN=0: any EXE or MEM match on either source.
REQ-024 MD hazard: md_busy=1 and (md_start=1 or md_read=1).
REQ-025 stall SHALL equal data hazard OR MD hazard. Outputs: wpcir = ~stall, bubble = stall; all combinational from current inputs and state.
REQ-026 flush_d SHALL be 1 only when DELAY_SLOT=0, br_taken=1 and stall=0. br_taken SHALL be ignored while stall=1.
REQ-027 The MD FSM SHALL have states IDLE, BUSY and DONE.
REQ-028 IDLE -> BUSY when md_start=1 and stall=0 (accept); load cnt = MD_LAT-1.
REQ-029 BUSY: decrement cnt each cycle; at cnt==1 go to DONE.
REQ-030 DONE: md_done=1 for one cycle. Then -> BUSY with cnt = MD_LAT-1 if a new md_start is accepted in that cycle, else -> IDLE.
REQ-031 md_busy SHALL be 1 in BUSY only. md_done SHALL rise exactly MD_LAT cycles after the accept edge.
REQ-032 In DONE, md_start and md_read SHALL NOT cause an MD hazard.
REQ-033 stall_cnt SHALL increment on each clock where stall=1 and hold at all-ones.

Reset
REQ-034 On reset=1 at a clock edge: FSM -> IDLE, cnt = 0, stall_cnt = 0, md_busy = 0, md_done = 0.
REQ-035 Reset mid-MD SHALL abort the operation; no md_done pulse follows.
REQ-036 Combinational outputs SHALL follow their inputs during reset; reset SHALL take priority over an accept in the same cycle.

Verification
REQ-037 FWD_EN=1, ern=5, ewreg=1, em2reg=0, rs=5, use_rs=1 -> fwda=01, wpcir=1. Same stimulus with mrn=5 also matching MEM -> fwda stays 01.
REQ-038 FWD_EN=1, ern=7, ewreg=1, em2reg=1, rt=7, use_rt=1 -> wpcir=0, bubble=1 for one cycle, stall_cnt=1. Next cycle with the instruction in MEM (mrn=7, mm2reg=1) -> fwdb=11.
REQ-039 ern=0, ewreg=1, rs=0 -> fwda=00, no stall. FWD_EN=0 with mrn=3, mwreg=1, rs=3 -> stall asserted, fwda=00.
REQ-040 MD_LAT=4: md_start accepted at cycle 0 -> md_busy=1 on cycles 1..3, md_done=1 on cycle 4. md_read at cycle 2 -> wpcir=0 on cycles 2..3, wpcir=1 on cycle 4.
REQ-041 DELAY_SLOT=0, br_taken=1, no hazard -> flush_d=1. Same stimulus during a load-use stall -> flush_d=0.
REQ-042 Reset asserted at cycle 2 of an MD operation -> md_busy=0 next cycle and no md_done pulse. stall_cnt=0. With SCW=4, a continuous stall saturates stall_cnt at 15.
